// File: rtl/rtp_pkg.sv
// Shared RTP definitions used by both the TX packetizer and the RX depacketizer.
package rtp_pkg;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} rtp_state_e;

  localparam int         RTP_HEADER_LENGTH = 12;
  localparam logic [1:0] RTP_VERSION       = 2'b10;
  localparam int         SEQ_OFS           = 2;
  localparam int         TS_OFS            = 4;
  localparam int         SSRC_OFS          = 8;

  typedef enum logic [2:0] {
    FLD_VPXCC, FLD_MPT, FLD_SEQ_HI, FLD_SEQ_LO, FLD_TS, FLD_SSRC
  } rtp_field_e;

  // Maps a header byte offset (0..11) to the field it belongs to.
  function automatic rtp_field_e hdr_field(input logic [3:0] idx);
    int i;
    i = int'(idx);
    if (i == 0)                            hdr_field = FLD_VPXCC;
    else if (i == 1)                       hdr_field = FLD_MPT;
    else if (i == SEQ_OFS)                 hdr_field = FLD_SEQ_HI;
    else if (i == SEQ_OFS + 1)             hdr_field = FLD_SEQ_LO;
    else if (i >= TS_OFS && i < SSRC_OFS)  hdr_field = FLD_TS;
    else                                   hdr_field = FLD_SSRC;
  endfunction

  // SSRC is transmitted MSB first, so offset SSRC_OFS carries bits [31:24].
  function automatic logic [7:0] ssrc_byte(input logic [31:0] ssrc, input logic [3:0] idx);
    logic [31:0] s;
    int sh;
    sh = SSRC_OFS + 3 - int'(idx);
    s  = ssrc >> (8 * sh);
    ssrc_byte = s[7:0];
  endfunction

endpackage

// File: rtl/rtp_sample_fifo.sv
// Single-clock 16-bit sample FIFO with registered read data; an empty read returns zero.
module rtp_sample_fifo #(
  parameter int DEPTH = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [15:0]             wr_data,
  input  logic                    rd_en,
  output logic [15:0]             rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          push, pop;

  // Fullness is judged on the current level, so a same-cycle pop never makes room.
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  assign rd_data = rd_data_q;
  assign level   = level_q;

  always_comb begin
    wptr_d    = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d    = pop  ? rptr_q + AW'(1) : rptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    if (rd_en)
      rd_data_d = empty ? 16'd0 : mem[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/rtp_rx_depacketizer.sv
// RTP receive depacketizer: header validation, sequence-gap tracking and PCM unpacking into a FIFO.
// Define RTP_RX_SSRC_CHECK_EN to reject packets whose SSRC differs from the SSRC parameter.
module rtp_rx_depacketizer
  import rtp_pkg::*;
#(
  parameter logic [6:0]  RTP_PT     = 7'd0,
  parameter logic [31:0] SSRC       = 32'h12345678,
  parameter int          FIFO_DEPTH = 1024,
  parameter int          CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         udp_rec_data_valid,
  input  logic [7:0]                   udp_rec_rdata,
  input  logic [15:0]                  udp_rec_data_length,
  input  logic                         wav_rden,
  output logic [15:0]                  wav_out_data,
  output logic                         wav_out_valid,
  output logic                         underrun,
  output logic [CNT_W-1:0]             pkt_ok_cnt,
  output logic [CNT_W-1:0]             pkt_err_cnt,
  output logic [CNT_W-1:0]             seq_gap_cnt,
  output logic [CNT_W-1:0]             ovf_cnt,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  rtp_state_e       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d, cnt_inc;
  logic [15:0]      seq_q, seq_d;
  logic [15:0]      exp_seq_q, exp_seq_d;
  logic             seq_valid_q, seq_valid_d;
  logic [7:0]       msb_q, msb_d;
  logic             push_q, push_d;
  logic [15:0]      push_data_q, push_data_d;
  logic [CNT_W-1:0] ok_q, ok_d, err_q, err_d, gap_q, gap_d, ovf_q, ovf_d;
  logic             out_valid_q, underrun_q;
  logic             ok_inc, err_inc, gap_inc, ovf_inc;
  logic             last_byte, byte_ok;
  logic [3:0]       hdr_idx;
  rtp_field_e       fld;
  logic             fifo_full, fifo_empty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    sat_inc = (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  assign cnt_inc   = cnt_q + 16'd1;
  assign last_byte = (cnt_inc >= udp_rec_data_length);
  assign hdr_idx   = (state_q == HEADER) ? cnt_q[3:0] : 4'd0;

  always_comb begin
    fld     = hdr_field(hdr_idx);
    byte_ok = 1'b1;
    case (fld)
      FLD_VPXCC: byte_ok = (udp_rec_rdata[7:6] == RTP_VERSION) && (udp_rec_rdata[4:0] == 5'd0)
                           && (udp_rec_data_length >= 16'(RTP_HEADER_LENGTH));
      FLD_MPT:   byte_ok = (udp_rec_rdata[6:0] == RTP_PT);
`ifdef RTP_RX_SSRC_CHECK_EN
      FLD_SSRC:  byte_ok = (udp_rec_rdata == ssrc_byte(SSRC, hdr_idx));
`else
`endif
      default:   byte_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    exp_seq_d   = exp_seq_q;
    seq_valid_d = seq_valid_q;
    msb_d       = msb_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    ok_inc      = 1'b0;
    err_inc     = 1'b0;
    gap_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (udp_rec_data_valid) begin
          cnt_d = 16'd1;
          if (byte_ok) begin
            state_d = HEADER;
          end else begin
            err_inc = 1'b1;
            state_d = (udp_rec_data_length <= 16'd1) ? IDLE : DROP;
          end
        end
      end
      HEADER: begin
        if (!udp_rec_data_valid) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (fld == FLD_SEQ_HI) seq_d[15:8] = udp_rec_rdata;
          if (fld == FLD_SEQ_LO) seq_d[7:0]  = udp_rec_rdata;
          if (!byte_ok) begin
            err_inc = 1'b1;
            state_d = last_byte ? IDLE : DROP;
          end else if (hdr_idx == 4'(RTP_HEADER_LENGTH - 1)) begin
            // The sequence number was completed at byte 3, so seq_q is final here.
            ok_inc      = 1'b1;
            gap_inc     = seq_valid_q && (seq_q != exp_seq_q);
            exp_seq_d   = seq_q + 16'd1;
            seq_valid_d = 1'b1;
            state_d     = last_byte ? IDLE : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!udp_rec_data_valid) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (!cnt_q[0]) begin
            msb_d = udp_rec_rdata;
          end else begin
            push_d      = 1'b1;
            push_data_d = {msb_q, udp_rec_rdata};
          end
          if (last_byte) state_d = IDLE;
        end
      end
      DROP: begin
        if (!udp_rec_data_valid) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (last_byte) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_inc = push_q && fifo_full;

  always_comb begin
    ok_d  = sat_inc(ok_q,  ok_inc);
    err_d = sat_inc(err_q, err_inc);
    gap_d = sat_inc(gap_q, gap_inc);
    ovf_d = sat_inc(ovf_q, ovf_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      seq_q       <= '0;
      exp_seq_q   <= '0;
      seq_valid_q <= 1'b0;
      msb_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ok_q        <= '0;
      err_q       <= '0;
      gap_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      exp_seq_q   <= exp_seq_d;
      seq_valid_q <= seq_valid_d;
      msb_q       <= msb_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      gap_q       <= gap_d;
      ovf_q       <= ovf_d;
      out_valid_q <= wav_rden;
      underrun_q  <= wav_rden && fifo_empty;
    end
  end

  rtp_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_q),
    .wr_data (push_data_q),
    .rd_en   (wav_rden),
    .rd_data (wav_out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign wav_out_valid = out_valid_q;
  assign underrun      = underrun_q;
  assign pkt_ok_cnt    = ok_q;
  assign pkt_err_cnt   = err_q;
  assign seq_gap_cnt   = gap_q;
  assign ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_rtp_rx_depacketizer.sv
// Directed, table-driven bench for rtp_rx_depacketizer (default parameters).
// Expectations for the SSRC packet follow RTP_RX_SSRC_CHECK_EN.
module tb_rtp_rx_depacketizer;

  localparam int FIFO_DEPTH = 1024;
  localparam logic [31:0] SSRC = 32'h12345678;

  logic        clk = 1'b0;
  logic        rst;
  logic        udp_rec_data_valid;
  logic [7:0]  udp_rec_rdata;
  logic [15:0] udp_rec_data_length;
  logic        wav_rden;
  logic [15:0] wav_out_data;
  logic        wav_out_valid;
  logic        underrun;
  logic [15:0] pkt_ok_cnt, pkt_err_cnt, seq_gap_cnt, ovf_cnt;
  logic [10:0] fifo_level;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];

  typedef struct {
    string       name;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] seq;
    int          len;
    int          nsent;
    logic [7:0]  pbase;
    int          ok;
    int          err;
    int          gap;
    int          lvl;
  } vec_t;

  vec_t vecs[14];

  rtp_rx_depacketizer dut (
    .clk                 (clk),
    .rst                 (rst),
    .udp_rec_data_valid  (udp_rec_data_valid),
    .udp_rec_rdata       (udp_rec_rdata),
    .udp_rec_data_length (udp_rec_data_length),
    .wav_rden            (wav_rden),
    .wav_out_data        (wav_out_data),
    .wav_out_valid       (wav_out_valid),
    .underrun            (underrun),
    .pkt_ok_cnt          (pkt_ok_cnt),
    .pkt_err_cnt         (pkt_err_cnt),
    .seq_gap_cnt         (seq_gap_cnt),
    .ovf_cnt             (ovf_cnt),
    .fifo_level          (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic make_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] seq,
                             input logic [31:0] ssrc, input int len, input logic [7:0] pbase);
    tx_q.delete();
    tx_q.push_back(b0);
    tx_q.push_back(b1);
    tx_q.push_back(seq[15:8]);
    tx_q.push_back(seq[7:0]);
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    tx_q.push_back(8'h44);
    tx_q.push_back(ssrc[31:24]);
    tx_q.push_back(ssrc[23:16]);
    tx_q.push_back(ssrc[15:8]);
    tx_q.push_back(ssrc[7:0]);
    for (int j = 0; j < len - 12; j++)
      tx_q.push_back(8'(int'(pbase) + j));
  endtask

  // Sends the first nsent bytes of tx_q; optionally strobes wav_rden on the cycle after the last byte.
  task automatic applyStimulus(input int len, input int nsent, input bit rd_at_end);
    for (int i = 0; i < nsent; i++) begin
      udp_rec_data_valid  = 1'b1;
      udp_rec_rdata       = (i < tx_q.size()) ? tx_q[i] : 8'h00;
      udp_rec_data_length = 16'(len);
      @(posedge clk); #1;
    end
    udp_rec_data_valid = 1'b0;
    udp_rec_rdata      = 8'h00;
    if (rd_at_end) wav_rden = 1'b1;
    @(posedge clk); #1;
    wav_rden = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_read(output logic [15:0] d, output logic v, output logic u);
    wav_rden = 1'b1;
    @(posedge clk); #1;
    wav_rden = 1'b0;
    d = wav_out_data;
    v = wav_out_valid;
    u = underrun;
  endtask

  logic [15:0] rd_d;
  logic        rd_v, rd_u;
  logic [15:0] drain_exp[5];
  int          exp_ok, exp_err;

  initial begin
    vecs[0]  = '{"bad_version",  8'h40, 8'h00, 16'h0006, 16, 16, 8'h00, 1, 1, 0, 0};
    vecs[1]  = '{"seq_gap",      8'h80, 8'h00, 16'h0007, 12, 12, 8'h00, 2, 1, 1, 0};
    vecs[2]  = '{"seq_next",     8'h80, 8'h00, 16'h0008, 12, 12, 8'h00, 3, 1, 1, 0};
    vecs[3]  = '{"seq_ffff",     8'h80, 8'h00, 16'hFFFF, 12, 12, 8'h00, 4, 1, 2, 0};
    vecs[4]  = '{"seq_wrap",     8'h80, 8'h00, 16'h0000, 12, 12, 8'h00, 5, 1, 2, 0};
    vecs[5]  = '{"bad_pt",       8'h80, 8'h60, 16'h0001, 12, 12, 8'h00, 5, 2, 2, 0};
    vecs[6]  = '{"x_bit",        8'h90, 8'h00, 16'h0001, 12, 12, 8'h00, 5, 3, 2, 0};
    vecs[7]  = '{"cc_nonzero",   8'h81, 8'h00, 16'h0001, 12, 12, 8'h00, 5, 4, 2, 0};
    vecs[8]  = '{"p_marker",     8'hA0, 8'h80, 16'h0001, 12, 12, 8'h00, 6, 4, 2, 0};
    vecs[9]  = '{"short_len",    8'h80, 8'h00, 16'h0002,  8,  8, 8'h00, 6, 5, 2, 0};
    vecs[10] = '{"trunc_hdr",    8'h80, 8'h00, 16'h0002, 20,  6, 8'h00, 6, 6, 2, 0};
    vecs[11] = '{"two_samples",  8'h80, 8'h00, 16'h0002, 16, 16, 8'h20, 7, 6, 2, 2};
    vecs[12] = '{"odd_len",      8'h80, 8'h00, 16'h0003, 15, 15, 8'h30, 8, 6, 2, 3};
    vecs[13] = '{"trunc_pay",    8'h80, 8'h00, 16'h0004, 20, 16, 8'h40, 9, 7, 2, 5};
    drain_exp = '{16'h2021, 16'h2223, 16'h3031, 16'h4041, 16'h4243};

    // Reset with inputs toggling.
    rst = 1'b1;
    udp_rec_data_length = 16'd16;
    for (int i = 0; i < 4; i++) begin
      udp_rec_data_valid = i[0];
      udp_rec_rdata      = 8'h80 + 8'(i);
      wav_rden           = ~i[0];
      @(posedge clk); #1;
    end
    checkOutput("rst_ok_cnt",    32'(pkt_ok_cnt),    0);
    checkOutput("rst_err_cnt",   32'(pkt_err_cnt),   0);
    checkOutput("rst_gap_cnt",   32'(seq_gap_cnt),   0);
    checkOutput("rst_ovf_cnt",   32'(ovf_cnt),       0);
    checkOutput("rst_level",     32'(fifo_level),    0);
    checkOutput("rst_out_valid", 32'(wav_out_valid), 0);
    checkOutput("rst_underrun",  32'(underrun),      0);
    checkOutput("rst_out_data",  32'(wav_out_data),  0);
    udp_rec_data_valid = 1'b0;
    udp_rec_rdata      = 8'h00;
    wav_rden           = 1'b0;
    rst                = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_read(rd_d, rd_v, rd_u);
    checkOutput("empty_rd_valid",    32'(rd_v), 1);
    checkOutput("empty_rd_underrun", 32'(rd_u), 1);
    checkOutput("empty_rd_data",     32'(rd_d), 0);

    // Basic packet with two hand-chosen samples.
    make_packet(8'h80, 8'h00, 16'h0005, SSRC, 12, 8'h00);
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h34);
    tx_q.push_back(8'hAB);
    tx_q.push_back(8'hCD);
    applyStimulus(16, 16, 1'b0);
    checkOutput("basic_ok_cnt", 32'(pkt_ok_cnt), 1);
    checkOutput("basic_level",  32'(fifo_level), 2);
    do_read(rd_d, rd_v, rd_u);
    checkOutput("basic_rd0_data",     32'(rd_d), 32'h1234);
    checkOutput("basic_rd0_underrun", 32'(rd_u), 0);
    do_read(rd_d, rd_v, rd_u);
    checkOutput("basic_rd1_data",     32'(rd_d), 32'hABCD);
    do_read(rd_d, rd_v, rd_u);
    checkOutput("basic_rd2_data",     32'(rd_d), 0);
    checkOutput("basic_rd2_underrun", 32'(rd_u), 1);
    checkOutput("basic_rd2_valid",    32'(rd_v), 1);

    for (int v = 0; v < 14; v++) begin
      make_packet(vecs[v].b0, vecs[v].b1, vecs[v].seq, SSRC, vecs[v].len, vecs[v].pbase);
      applyStimulus(vecs[v].len, vecs[v].nsent, 1'b0);
      checkOutput({vecs[v].name, "_ok"},    32'(pkt_ok_cnt),  vecs[v].ok);
      checkOutput({vecs[v].name, "_err"},   32'(pkt_err_cnt), vecs[v].err);
      checkOutput({vecs[v].name, "_gap"},   32'(seq_gap_cnt), vecs[v].gap);
      checkOutput({vecs[v].name, "_level"}, 32'(fifo_level),  vecs[v].lvl);
    end

    // Drain the samples left by the table and confirm the output holds between requests.
    for (int k = 0; k < 5; k++) begin
      do_read(rd_d, rd_v, rd_u);
      checkOutput($sformatf("drain%0d_data", k), 32'(rd_d), 32'(drain_exp[k]));
      checkOutput($sformatf("drain%0d_underrun", k), 32'(rd_u), 0);
      if (k == 0) begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("hold_data",  32'(wav_out_data),  32'(drain_exp[0]));
        checkOutput("hold_valid", 32'(wav_out_valid), 0);
      end
    end
    do_read(rd_d, rd_v, rd_u);
    checkOutput("drain_end_underrun", 32'(rd_u), 1);
    checkOutput("drain_end_data",     32'(rd_d), 0);
    checkOutput("drain_end_level",    32'(fifo_level), 0);

    // Overfill by two samples.
    make_packet(8'h80, 8'h00, 16'h0005, SSRC, 12 + 2 * (FIFO_DEPTH + 2), 8'h50);
    applyStimulus(12 + 2 * (FIFO_DEPTH + 2), 12 + 2 * (FIFO_DEPTH + 2), 1'b0);
    checkOutput("fill_level", 32'(fifo_level), FIFO_DEPTH);
    checkOutput("fill_ovf",   32'(ovf_cnt),    2);
    checkOutput("fill_ok",    32'(pkt_ok_cnt), 10);

    // Write to a full FIFO in the same cycle as a read: the write is still dropped.
    make_packet(8'h80, 8'h00, 16'h0006, SSRC, 14, 8'h60);
    applyStimulus(14, 14, 1'b1);
    checkOutput("full_rw_ovf",   32'(ovf_cnt),      3);
    checkOutput("full_rw_level", 32'(fifo_level),   FIFO_DEPTH - 1);
    checkOutput("full_rw_data",  32'(wav_out_data), 32'h5051);

    // Push and pop together below full: level unchanged.
    make_packet(8'h80, 8'h00, 16'h0007, SSRC, 14, 8'h70);
    applyStimulus(14, 14, 1'b1);
    checkOutput("rw_ovf",   32'(ovf_cnt),      3);
    checkOutput("rw_level", 32'(fifo_level),   FIFO_DEPTH - 1);
    checkOutput("rw_data",  32'(wav_out_data), 32'h5253);
    checkOutput("rw_ok",    32'(pkt_ok_cnt),   12);
    checkOutput("rw_gap",   32'(seq_gap_cnt),  2);

    // Foreign SSRC.
`ifdef RTP_RX_SSRC_CHECK_EN
    exp_ok  = 12;
    exp_err = 8;
`else
    exp_ok  = 13;
    exp_err = 7;
`endif
    make_packet(8'h80, 8'h00, 16'h0008, 32'hDEADBEEF, 12, 8'h00);
    applyStimulus(12, 12, 1'b0);
    checkOutput("ssrc_ok",  32'(pkt_ok_cnt),  exp_ok);
    checkOutput("ssrc_err", 32'(pkt_err_cnt), exp_err);
    checkOutput("ssrc_gap", 32'(seq_gap_cnt), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rtp_rx_depacketizer.md
Name: rtp_rx_depacketizer

Overview:
- Receive-side counterpart of the RTP audio packetizer.
- Consumes the UDP receive byte stream, parses and validates the 12-byte RTP header, tracks sequence numbers, and unpacks big-endian 16-bit PCM samples into a sample FIFO.
- The FIFO is drained one sample per codec read strobe toward the WM8731 DAC path.

Parameters:
- RTP_PT, 7'd0: required RTP payload type.
- SSRC, 32'h12345678: expected stream SSRC; used only when SSRC_CHECK_EN is defined.
- FIFO_DEPTH, 1024: sample FIFO depth in 16-bit words; power of two.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- udp_rec_data_valid  in  1  one payload byte per high cycle; a packet is one contiguous high run.
- udp_rec_rdata  in  8  UDP payload byte, first byte = RTP byte 0.
- udp_rec_data_length  in  16  UDP payload length in bytes; stable from the first byte to the end of the packet.
- wav_rden  in  1  codec sample request, single-cycle strobe.
- wav_out_data  out  16  signed sample returned for the last request.
- wav_out_valid  out  1  one-cycle pulse, one cycle after wav_rden.
- underrun  out  1  one-cycle pulse with wav_out_valid when the FIFO was empty.
- pkt_ok_cnt  out  CNT_W  accepted packets, saturating.
- pkt_err_cnt  out  CNT_W  rejected or truncated packets, saturating.
- seq_gap_cnt  out  CNT_W  sequence discontinuities, saturating.
- ovf_cnt  out  CNT_W  samples dropped because the FIFO was full, saturating.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: every output 0, FIFO empty, state IDLE, seq_valid flag cleared. Reset mid-packet abandons the packet; the remaining bytes of that packet are parsed as a new packet and rejected.
- State machine: IDLE, HEADER, PAYLOAD, DROP.
- IDLE -> HEADER on the first valid byte; that byte is header byte 0. A byte counter counts accepted bytes.
- HEADER checks, applied as each byte arrives:
  - byte0[7:6]==2'b10, byte0[4:0]==0 (X=0, CC=0); byte0[5] (P) is ignored.
  - byte1[6:0]==RTP_PT; the marker bit is ignored.
  - Bytes 2-3 form the sequence number. Bytes 4-7 (timestamp) are ignored. Bytes 8-11 form the SSRC.
  - udp_rec_data_length must be >= 12.
  - Any check failure -> DROP.
  - After byte 11 passes: packet is accepted (pkt_ok_cnt++), then:
    - length==12 -> IDLE;
    - otherwise -> PAYLOAD.
- Sequence tracking on accept:
  - If seq_valid and seq != expected: seq_gap_cnt++.
  - Then expected = seq+1, computed mod 2^16 (0xFFFF -> 0x0000 is not a gap), and seq_valid is set.
  - The first packet after reset never counts a gap.
- PAYLOAD:
  - Bytes pair big-endian: the even byte is the MSB.
  - The sample is written to the FIFO on the cycle after its LSB byte.
  - If the FIFO is full at write time, the sample is dropped and ovf_cnt++. A same-cycle read does not free space for that write.
  - An odd trailing byte is discarded.
  - Exit to IDLE on the cycle after byte count == udp_rec_data_length.
- DROP: pkt_err_cnt++ on entry. Remaining bytes are ignored; return to IDLE when count reaches the length.
- Early valid deassert (count < length) in HEADER, PAYLOAD or DROP:
  - pkt_err_cnt++, except in DROP where the packet is already counted.
  - Go to IDLE.
  - Samples already written stay in the FIFO.
  - A packet truncated in PAYLOAD stays counted in pkt_ok_cnt.
- A valid gap of at least one cycle is required between packets.
- Read side:
  - wav_rden with FIFO non-empty: pop; next cycle wav_out_data = popped sample and wav_out_valid=1.
  - wav_rden with FIFO empty: wav_out_data = 0, wav_out_valid=1, underrun=1.
  - wav_out_data holds its value between requests.
- Simultaneous push and pop: both occur; fifo_level is unchanged.
- Counters saturate at all-ones.

Optional Feature:
- Macro RTP_RX_SSRC_CHECK_EN.
- Defined: bytes 8-11 must equal SSRC, else DROP.
- Undefined: SSRC bytes are ignored and any SSRC is accepted.

Decomposition:
- Shared package rtp_pkg:
  - state enum {IDLE, HEADER, PAYLOAD, DROP};
  - RTP_HEADER_LENGTH=12, RTP_VERSION=2'b10;
  - header byte offsets (SEQ_OFS=2, TS_OFS=4, SSRC_OFS=8).
- The TX packetizer also uses rtp_pkg.
- One sub-module: rtp_sample_fifo, a synchronous single-clock FIFO (16-bit, FIFO_DEPTH, full/empty/level, registered read data).

Test Plan:
1. Reset with inputs toggling -> all outputs 0, fifo_level=0; wav_rden -> wav_out_data=0, underrun=1.
2. Length-16 packet 80 00 00 05 | 4 timestamp bytes | 12 34 56 78 | 12 34 AB CD -> pkt_ok_cnt=1, fifo_level=2; two reads return 0x1234 then 0xABCD; a third read gives 0x0000 with underrun=1.
3. Byte0=0x40 (V=1), length 16 -> pkt_err_cnt=1, fifo_level=0; the next valid packet is accepted.
4. Sequence numbers 5, 7 -> seq_gap_cnt=1; then 8 -> no change; then 0xFFFF, 0x0000 -> seq_gap_cnt=2 (0xFFFF is a gap vs 9, the wrap to 0x0000 is not).
5. Length 20, valid drops after 6 bytes -> pkt_err_cnt++, state IDLE; a following good packet is parsed correctly. Odd length 15 -> one sample written, last byte discarded.
6. Fill FIFO_DEPTH samples, then send 2 more -> ovf_cnt=2, fifo_level=FIFO_DEPTH. With RTP_RX_SSRC_CHECK_EN defined, SSRC 0xDEADBEEF -> pkt_err_cnt++; undefined -> accepted.
